ccff_chain_programmer: RTL

- Serial writer for the configuration-chain protocol (ccff_head in, ccff_tail out, DFFRQ flops clocked by prog_clk).
- Accepts configuration words from a bitstream source over a valid/ready handshake and serialises them onto ccff_head.
- Emits a shift enable that gates prog_clk to the chain.
- Optional second pass re-streams the same bitstream and compares ccff_tail against it for readback verification without corrupting the loaded configuration.

---
 rtl/ccff_chain_programmer_if.sv | 8 +
 rtl/ccff_chain_programmer.sv | 112 +++++++++++
 2 files changed

// File: rtl/ccff_chain_programmer_if.sv
// ccff_chain_programmer_if: bitstream word handshake between a source and the chain programmer
interface ccff_chain_programmer_if #(parameter int WORD_W = 8);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  modport master (output word_valid, word_data, input word_ready);
  modport slave (input word_valid, word_data, output word_ready);
endinterface

// File: rtl/ccff_chain_programmer.sv
// ccff_chain_programmer: serialises bitstream words onto a ccff chain, with optional readback verify pass
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 17,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic                   prog_clk,
  input  logic                   pReset,
  input  logic                   start,
  input  logic                   verify,
  ccff_chain_programmer_if.slave bus,
  output logic                   ccff_head,
  output logic                   ccff_shift_en,
  input  logic                   ccff_tail,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       err_count
);
  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W:0] L_CHAIN = (CNT_W+1)'(CHAIN_LEN);
  localparam logic [CNT_W:0] L_WORD = (CNT_W+1)'(WORD_W);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t            r_state;
  logic [WORD_W-1:0] r_buf;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WB_W-1:0]   r_left;
  logic              r_pass, r_ven, r_head, r_shift_en, r_ready, r_busy, r_done, r_mis;
  logic [CNT_W-1:0]  r_err;
  logic [CNT_W:0]    w_rem;
  logic [WB_W-1:0]   w_nb;
  logic              w_end;
  always_comb begin
    w_rem = L_CHAIN - {1'b0, r_bit_cnt};
    w_nb = (w_rem > L_WORD) ? WB_W'(WORD_W) : w_rem[WB_W-1:0];
    w_end = ({1'b0, r_bit_cnt} + (CNT_W+1)'(1)) == L_CHAIN;
  end
  // r_head holds the bit being presented; r_left counts bits still to go from the current word
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state    <= IDLE;
      r_buf      <= '0;
      r_bit_cnt  <= '0;
      r_left     <= '0;
      r_pass     <= 1'b0;
      r_ven      <= 1'b0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mis      <= 1'b0;
      r_err      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state   <= FETCH;
          r_ven     <= verify;
          r_pass    <= 1'b0;
          r_bit_cnt <= '0;
          r_mis     <= 1'b0;
          r_err     <= '0;
          r_busy    <= 1'b1;
          r_ready   <= 1'b1;
        end
        FETCH: if (bus.word_valid) begin
          r_state    <= SHIFT;
          r_ready    <= 1'b0;
          r_shift_en <= 1'b1;
          r_head     <= bus.word_data[0];
          r_buf      <= bus.word_data >> 1;
          r_left     <= w_nb;
        end
        SHIFT: begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_left    <= r_left - WB_W'(1);
          if (r_pass && (ccff_tail != r_head)) begin
            r_mis <= 1'b1;
            if (r_err != '1) r_err <= r_err + CNT_W'(1);
          end
          if (r_left == WB_W'(1)) begin
            r_shift_en <= 1'b0;
            if (w_end && (r_pass || !r_ven)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= FETCH;
              r_ready <= 1'b1;
              if (w_end) begin
                r_pass    <= 1'b1;
                r_bit_cnt <= '0;
              end
            end
          end else begin
            r_head <= r_buf[0];
            r_buf  <= r_buf >> 1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.word_ready = r_ready;
  assign ccff_head      = r_head;
  assign ccff_shift_en  = r_shift_en;
  assign busy           = r_busy;
  assign done           = r_done;
  assign mismatch       = r_mis;
  assign err_count      = r_err;
endmodule
